stg_hazard_ctl: RTL and testbench

Issue controller for the decode stage: a register scoreboard that tracks in-flight GP/SR writes between decode and writeback, stalls the decoded instruction on read-after-write or write-after-write-overflow hazards, sequences multi-cycle flushes after taken branches and drains the pipeline for halt requests. It sits beside the ID/EX boundary. It consumes the decoded fields latched by the decode stage and writeback strobes, and it drives the stall, flush and bubble controls of the fetch and decode stages.

---
 rtl/stg_hazard_ctl.sv | 209 ++++++++++++++++++++
 tb/tb_stg_hazard_ctl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stg_hazard_ctl.sv
// Decode-stage issue controller: per-register pending-write scoreboard, RAW/WAW-overflow
// stall generation, taken-branch flush sequencing and halt drain.
module stg_hazard_ctl #(
  parameter int P_NGP       = 16,
  parameter int P_NSR       = 4,
  parameter int P_FLUSH_CYC = 2
) (
  input  logic                     iw_clk,
  input  logic                     iw_rst,
  input  logic                     iw_id_valid,
  input  logic [$clog2(P_NGP)-1:0] iw_id_tgt_gp,
  input  logic                     iw_id_tgt_gp_we,
  input  logic                     iw_id_tgt_gp_rd,
  input  logic [$clog2(P_NGP)-1:0] iw_id_src_gp,
  input  logic                     iw_id_src_gp_en,
  input  logic [$clog2(P_NSR)-1:0] iw_id_tgt_sr,
  input  logic                     iw_id_tgt_sr_we,
  input  logic [$clog2(P_NSR)-1:0] iw_id_src_sr,
  input  logic                     iw_id_src_sr_en,
  input  logic                     iw_wb_gp_we,
  input  logic [$clog2(P_NGP)-1:0] iw_wb_gp,
  input  logic                     iw_wb_sr_we,
  input  logic [$clog2(P_NSR)-1:0] iw_wb_sr,
  input  logic                     iw_br_taken,
  input  logic                     iw_halt_req,
  input  logic                     iw_resume,
  output logic                     ow_stall,
  output logic                     ow_issue,
  output logic                     ow_bubble,
  output logic                     ow_flush,
  output logic                     ow_halted,
  output logic                     ow_busy,
  output logic                     ow_err,
  output logic [1:0]               ow_state
);

  localparam int GW = $clog2(P_NGP);
  localparam int SW = $clog2(P_NSR);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t     state_reg;
  logic [2:0] flush_cnt_reg;
  logic       flush_reg;
  logic       halted_reg;
  logic       err_reg;

  logic [2*P_NGP-1:0] cnt_gp_flat;
  logic [2*P_NSR-1:0] cnt_sr_flat;
  logic [P_NGP-1:0]   gp_nz, gp_nz_next, gp_underflow;
  logic [P_NSR-1:0]   sr_nz, sr_nz_next, sr_underflow;

  logic [1:0] cnt_src_gp, cnt_tgt_gp, cnt_src_sr, cnt_tgt_sr;
  logic       haz;
  logic       issue;
  logic       busy_next;

  // Hazard looks only at registered counters; a same-cycle writeback does not clear it.
  assign cnt_src_gp = cnt_gp_flat[2*iw_id_src_gp +: 2];
  assign cnt_tgt_gp = cnt_gp_flat[2*iw_id_tgt_gp +: 2];
  assign cnt_src_sr = cnt_sr_flat[2*iw_id_src_sr +: 2];
  assign cnt_tgt_sr = cnt_sr_flat[2*iw_id_tgt_sr +: 2];

  assign haz = (iw_id_src_gp_en & (cnt_src_gp != 2'd0))
             | (iw_id_tgt_gp_rd & (cnt_tgt_gp != 2'd0))
             | (iw_id_src_sr_en & (cnt_src_sr != 2'd0))
             | (iw_id_tgt_gp_we & (cnt_tgt_gp == 2'd3))
             | (iw_id_tgt_sr_we & (cnt_tgt_sr == 2'd3));

  assign issue     = iw_id_valid & (state_reg == ST_RUN) & ~haz;
  assign ow_issue  = issue;
  assign ow_stall  = iw_id_valid & (state_reg == ST_RUN) & haz;
  assign ow_bubble = ~issue;

  genvar gi;
  generate
    for (gi = 0; gi < P_NGP; gi++) begin : g_gp
      logic [1:0] cnt_reg;
      logic [1:0] cnt_next;
      logic       inc;
      logic       dec;

      assign inc = issue & iw_id_tgt_gp_we & (iw_id_tgt_gp == GW'(gi));
      assign dec = iw_wb_gp_we & (iw_wb_gp == GW'(gi));

      always_comb begin
        cnt_next = cnt_reg;
        if (inc && !(dec && cnt_reg != 2'd0))
          cnt_next = cnt_reg + 2'd1;
        else if (!inc && dec && cnt_reg != 2'd0)
          cnt_next = cnt_reg - 2'd1;
      end

      always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) cnt_reg <= 2'd0;
        else        cnt_reg <= cnt_next;
      end

      assign cnt_gp_flat[2*gi +: 2] = cnt_reg;
      assign gp_nz[gi]              = (cnt_reg != 2'd0);
      assign gp_nz_next[gi]         = (cnt_next != 2'd0);
      assign gp_underflow[gi]       = dec & (cnt_reg == 2'd0);
    end

    for (gi = 0; gi < P_NSR; gi++) begin : g_sr
      logic [1:0] cnt_reg;
      logic [1:0] cnt_next;
      logic       inc;
      logic       dec;

      assign inc = issue & iw_id_tgt_sr_we & (iw_id_tgt_sr == SW'(gi));
      assign dec = iw_wb_sr_we & (iw_wb_sr == SW'(gi));

      always_comb begin
        cnt_next = cnt_reg;
        if (inc && !(dec && cnt_reg != 2'd0))
          cnt_next = cnt_reg + 2'd1;
        else if (!inc && dec && cnt_reg != 2'd0)
          cnt_next = cnt_reg - 2'd1;
      end

      always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) cnt_reg <= 2'd0;
        else        cnt_reg <= cnt_next;
      end

      assign cnt_sr_flat[2*gi +: 2] = cnt_reg;
      assign sr_nz[gi]              = (cnt_reg != 2'd0);
      assign sr_nz_next[gi]         = (cnt_next != 2'd0);
      assign sr_underflow[gi]       = dec & (cnt_reg == 2'd0);
    end
  endgenerate

  assign ow_busy   = (|gp_nz) | (|sr_nz);
  assign busy_next = (|gp_nz_next) | (|sr_nz_next);

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst)
      err_reg <= 1'b0;
    else if ((|gp_underflow) | (|sr_underflow))
      err_reg <= 1'b1;
  end

  // DRAIN finishes on the post-writeback counter values so a retiring last write halts next cycle.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_reg     <= ST_RUN;
      flush_cnt_reg <= 3'd0;
      flush_reg     <= 1'b0;
      halted_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (iw_br_taken) begin
            state_reg     <= ST_FLUSH;
            flush_cnt_reg <= 3'(P_FLUSH_CYC);
            flush_reg     <= 1'b1;
          end else if (iw_halt_req) begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_FLUSH: begin
          if (iw_br_taken) begin
            flush_cnt_reg <= 3'(P_FLUSH_CYC);
          end else if (flush_cnt_reg <= 3'd1) begin
            state_reg     <= ST_RUN;
            flush_cnt_reg <= 3'd0;
            flush_reg     <= 1'b0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - 3'd1;
          end
        end
        ST_DRAIN: begin
          if (iw_br_taken) begin
            state_reg     <= ST_FLUSH;
            flush_cnt_reg <= 3'(P_FLUSH_CYC);
            flush_reg     <= 1'b1;
          end else if (!busy_next) begin
            state_reg  <= ST_HALTED;
            halted_reg <= 1'b1;
          end
        end
        ST_HALTED: begin
          if (iw_resume) begin
            state_reg  <= ST_RUN;
            halted_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_RUN;
          flush_cnt_reg <= 3'd0;
          flush_reg     <= 1'b0;
          halted_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign ow_flush  = flush_reg;
  assign ow_halted = halted_reg;
  assign ow_err    = err_reg;
  assign ow_state  = state_reg;

endmodule

// File: tb/tb_stg_hazard_ctl.sv
// Bench for stg_hazard_ctl: directed test-plan scenarios then random traffic,
// every cycle checked against a count-per-register reference model.
module tb_stg_hazard_ctl;
  localparam int NGP = 16;
  localparam int NSR = 4;
  localparam int PF  = 2;

  logic       iw_clk = 1'b0;
  logic       iw_rst;
  logic       iw_id_valid;
  logic [3:0] iw_id_tgt_gp;
  logic       iw_id_tgt_gp_we;
  logic       iw_id_tgt_gp_rd;
  logic [3:0] iw_id_src_gp;
  logic       iw_id_src_gp_en;
  logic [1:0] iw_id_tgt_sr;
  logic       iw_id_tgt_sr_we;
  logic [1:0] iw_id_src_sr;
  logic       iw_id_src_sr_en;
  logic       iw_wb_gp_we;
  logic [3:0] iw_wb_gp;
  logic       iw_wb_sr_we;
  logic [1:0] iw_wb_sr;
  logic       iw_br_taken;
  logic       iw_halt_req;
  logic       iw_resume;
  logic       ow_stall, ow_issue, ow_bubble, ow_flush, ow_halted, ow_busy, ow_err;
  logic [1:0] ow_state;

  stg_hazard_ctl #(.P_NGP(NGP), .P_NSR(NSR), .P_FLUSH_CYC(PF)) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_id_valid(iw_id_valid),
    .iw_id_tgt_gp(iw_id_tgt_gp), .iw_id_tgt_gp_we(iw_id_tgt_gp_we),
    .iw_id_tgt_gp_rd(iw_id_tgt_gp_rd), .iw_id_src_gp(iw_id_src_gp),
    .iw_id_src_gp_en(iw_id_src_gp_en), .iw_id_tgt_sr(iw_id_tgt_sr),
    .iw_id_tgt_sr_we(iw_id_tgt_sr_we), .iw_id_src_sr(iw_id_src_sr),
    .iw_id_src_sr_en(iw_id_src_sr_en), .iw_wb_gp_we(iw_wb_gp_we), .iw_wb_gp(iw_wb_gp),
    .iw_wb_sr_we(iw_wb_sr_we), .iw_wb_sr(iw_wb_sr), .iw_br_taken(iw_br_taken),
    .iw_halt_req(iw_halt_req), .iw_resume(iw_resume), .ow_stall(ow_stall),
    .ow_issue(ow_issue), .ow_bubble(ow_bubble), .ow_flush(ow_flush),
    .ow_halted(ow_halted), .ow_busy(ow_busy), .ow_err(ow_err), .ow_state(ow_state)
  );

  always #5 iw_clk = ~iw_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: pending-write count per register, mode (0 RUN,1 FLUSH,2 DRAIN,3 HALTED).
  int m_gp [NGP];
  int m_sr [NSR];
  int m_st, m_fl, m_err;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit m_haz();
    return (iw_id_src_gp_en && m_gp[iw_id_src_gp] != 0) ||
           (iw_id_tgt_gp_rd && m_gp[iw_id_tgt_gp] != 0) ||
           (iw_id_src_sr_en && m_sr[iw_id_src_sr] != 0) ||
           (iw_id_tgt_gp_we && m_gp[iw_id_tgt_gp] == 3) ||
           (iw_id_tgt_sr_we && m_sr[iw_id_tgt_sr] == 3);
  endfunction

  function automatic bit m_busy();
    bit b = 0;
    foreach (m_gp[i]) if (m_gp[i] != 0) b = 1;
    foreach (m_sr[i]) if (m_sr[i] != 0) b = 1;
    return b;
  endfunction

  task automatic model_reset();
    foreach (m_gp[i]) m_gp[i] = 0;
    foreach (m_sr[i]) m_sr[i] = 0;
    m_st = 0; m_fl = 0; m_err = 0;
  endtask

  task automatic check_now();
    bit h, run, ei;
    h   = m_haz();
    run = iw_id_valid && (m_st == 0);
    ei  = run && !h;
    chk("issue",  {1'b0, ow_issue},  {1'b0, ei});
    chk("stall",  {1'b0, ow_stall},  {1'b0, run && h});
    chk("bubble", {1'b0, ow_bubble}, {1'b0, !ei});
    chk("flush",  {1'b0, ow_flush},  {1'b0, m_st == 1});
    chk("halted", {1'b0, ow_halted}, {1'b0, m_st == 3});
    chk("state",  ow_state,          2'(m_st));
    chk("busy",   {1'b0, ow_busy},   {1'b0, m_busy()});
    chk("err",    {1'b0, ow_err},    {1'b0, m_err != 0});
  endtask

  task automatic model_step();
    bit iss;
    int old_gp, old_sr;
    iss    = iw_id_valid && (m_st == 0) && !m_haz();
    old_gp = m_gp[iw_wb_gp];
    old_sr = m_sr[iw_wb_sr];
    if (iss && iw_id_tgt_gp_we) m_gp[iw_id_tgt_gp]++;
    if (iss && iw_id_tgt_sr_we) m_sr[iw_id_tgt_sr]++;
    if (iw_wb_gp_we) begin
      if (old_gp == 0) m_err = 1; else m_gp[iw_wb_gp]--;
    end
    if (iw_wb_sr_we) begin
      if (old_sr == 0) m_err = 1; else m_sr[iw_wb_sr]--;
    end
    if (iss)
      $display("cycle %0d issue gp_we=%0d gp=%0d sr_we=%0d sr=%0d", cyc,
               iw_id_tgt_gp_we, iw_id_tgt_gp, iw_id_tgt_sr_we, iw_id_tgt_sr);
    case (m_st)
      0: if (iw_br_taken) begin m_st = 1; m_fl = PF; end
         else if (iw_halt_req) m_st = 2;
      1: if (iw_br_taken) m_fl = PF;
         else if (m_fl == 1) m_st = 0;
         else m_fl--;
      2: if (iw_br_taken) begin m_st = 1; m_fl = PF; end
         else if (!m_busy()) m_st = 3;
      default: if (iw_resume) m_st = 0;
    endcase
  endtask

  // Inputs are applied at posedge+1; outputs are checked at posedge+2.
  task automatic cycle();
    #1;
    check_now();
    model_step();
    @(posedge iw_clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    iw_rst = 1'b1;
    #1;
    model_reset();
    check_now();
    @(posedge iw_clk);
    #1;
    iw_rst = 1'b0;
    cyc++;
  endtask

  task automatic idle_in();
    iw_id_valid = 0; iw_id_tgt_gp = 0; iw_id_tgt_gp_we = 0; iw_id_tgt_gp_rd = 0;
    iw_id_src_gp = 0; iw_id_src_gp_en = 0; iw_id_tgt_sr = 0; iw_id_tgt_sr_we = 0;
    iw_id_src_sr = 0; iw_id_src_sr_en = 0; iw_wb_gp_we = 0; iw_wb_gp = 0;
    iw_wb_sr_we = 0; iw_wb_sr = 0; iw_br_taken = 0; iw_halt_req = 0; iw_resume = 0;
  endtask

  task automatic set_id(input bit v, input int tgt, input bit we, input bit rd,
                        input int src, input bit sen);
    iw_id_valid = v; iw_id_tgt_gp = 4'(tgt); iw_id_tgt_gp_we = we;
    iw_id_tgt_gp_rd = rd; iw_id_src_gp = 4'(src); iw_id_src_gp_en = sen;
  endtask

  task automatic wb_gp(input bit en, input int r);
    iw_wb_gp_we = en; iw_wb_gp = 4'(r);
  endtask

  initial begin
    int r;
    idle_in();
    model_reset();
    // During reset the combinational issue path is live with empty counters.
    set_id(1, 3, 1, 1, 3, 1);
    do_reset();

    // RAW on r3: stall until the cycle after its writeback.
    idle_in(); set_id(1, 3, 1, 0, 0, 0); cycle();
    set_id(1, 0, 0, 0, 3, 1); cycle(); cycle();
    wb_gp(1, 3); cycle();
    wb_gp(0, 0); cycle();
    idle_in(); cycle();

    // WAW overflow on r5: fourth write waits for the first writeback.
    set_id(1, 5, 1, 0, 0, 0); cycle(); cycle(); cycle();
    cycle(); cycle();
    wb_gp(1, 5); cycle();
    wb_gp(0, 0); cycle();
    idle_in(); wb_gp(1, 5); cycle(); cycle(); cycle();
    wb_gp(0, 0); cycle();

    // Issue and retire r7 in the same cycle; SR path exercised with s2.
    set_id(1, 7, 1, 0, 0, 0); cycle();
    wb_gp(1, 7); cycle();
    idle_in(); iw_id_valid = 1; iw_id_src_sr = 2; iw_id_src_sr_en = 1;
    iw_id_tgt_sr = 2; iw_id_tgt_sr_we = 1; cycle();
    iw_wb_sr_we = 1; iw_wb_sr = 2; cycle();
    idle_in(); wb_gp(1, 7); cycle();
    idle_in(); cycle();

    // Taken branch, then back-to-back branches extending the flush.
    iw_br_taken = 1; set_id(1, 1, 0, 0, 0, 0); cycle();
    iw_br_taken = 0; cycle(); cycle(); cycle();
    iw_br_taken = 1; cycle(); cycle();
    iw_br_taken = 0; cycle(); cycle(); cycle(); cycle();

    // Halt with one write pending, retire it, then resume.
    idle_in(); set_id(1, 9, 1, 0, 0, 0); cycle();
    idle_in(); iw_halt_req = 1; cycle(); cycle();
    wb_gp(1, 9); cycle();
    wb_gp(0, 0); iw_halt_req = 0; set_id(1, 2, 0, 0, 0, 0); cycle(); cycle();
    iw_resume = 1; cycle();
    iw_resume = 0; cycle();

    // Halt interrupted by an asynchronous reset while draining.
    idle_in(); set_id(1, 4, 1, 0, 0, 0); cycle();
    idle_in(); iw_halt_req = 1; cycle(); cycle();
    idle_in(); do_reset(); cycle();

    // Retiring an idle register sets the sticky error until reset.
    wb_gp(1, 2); cycle();
    wb_gp(0, 0); cycle(); cycle(); cycle();
    do_reset(); cycle();

    // Random traffic concentrated on a few registers to provoke hazards.
    for (int n = 0; n < 1500; n++) begin
      idle_in();
      iw_id_valid     = ($urandom_range(0, 3) != 0);
      iw_id_tgt_gp    = 4'($urandom_range(0, 3) == 0 ? $urandom_range(0, NGP-1) : $urandom_range(0, 3));
      iw_id_tgt_gp_we = $urandom_range(0, 1);
      iw_id_tgt_gp_rd = ($urandom_range(0, 3) == 0);
      iw_id_src_gp    = 4'($urandom_range(0, 3));
      iw_id_src_gp_en = $urandom_range(0, 1);
      iw_id_tgt_sr    = 2'($urandom_range(0, NSR-1));
      iw_id_tgt_sr_we = ($urandom_range(0, 2) == 0);
      iw_id_src_sr    = 2'($urandom_range(0, NSR-1));
      iw_id_src_sr_en = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, NGP-1);
      if (m_gp[r] == 0) r = $urandom_range(0, 3);
      if (m_gp[r] != 0 && $urandom_range(0, 1) == 1) wb_gp(1, r);
      r = $urandom_range(0, NSR-1);
      if (m_sr[r] != 0 && $urandom_range(0, 1) == 1) begin
        iw_wb_sr_we = 1; iw_wb_sr = 2'(r);
      end
      iw_br_taken = ($urandom_range(0, 15) == 0);
      iw_halt_req = ($urandom_range(0, 24) == 0);
      iw_resume   = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
